// File: rtl/smul_result_unpacker.sv
// Unpacks one packed 64-bit smul MAC result into a valid/ready stream of lane beats.
// Optional saturating beat counter on perf_lanes when SMUL_UNPACK_PERF_EN is defined.
module smul_result_unpacker #(
    parameter int SIGNED_EXT = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic [3:0]       in_mask,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [1:0]       out_lane,
    output logic             out_last
`ifdef SMUL_UNPACK_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_lanes
`endif
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t      state, state_nx;
    logic [63:0] word_q;
    logic [3:0]  pend_q;
    logic        accept, hs, load, adv;
    logic [3:0]  src_mask, nx_rest;
    logic [63:0] src_data;
    logic [1:0]  nx_lane;

    function automatic logic [1:0] low_lane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [63:0] ext_lane(input logic [63:0] d, input logic [1:0] l);
        logic sx;
        sx = (SIGNED_EXT != 0);
        case (l)
            2'd0:    return {{56{sx & d[7]}},  d[7:0]};
            2'd1:    return {{56{sx & d[15]}}, d[15:8]};
            2'd2:    return {{48{sx & d[31]}}, d[31:16]};
            default: return {{32{sx & d[63]}}, d[63:32]};
        endcase
    endfunction

    function automatic logic [63:0] lane_bits(input logic [3:0] m);
        return {{32{m[3]}}, {16{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    assign in_ready = !sclr && (!out_valid || (out_ready && out_last));
    assign accept   = in_valid && in_ready;
    assign hs       = out_valid && out_ready;
    assign load     = accept && (in_mask != 4'd0);
    assign adv      = hs && !out_last;

    // Next beat comes from the incoming word on load, otherwise from the held remainder.
    always_comb begin
        src_mask = load ? in_mask : pend_q;
        src_data = load ? in_data : word_q;
        nx_lane  = low_lane(src_mask);
        nx_rest  = src_mask & ~(4'b0001 << nx_lane);
    end

    always_ff @(posedge clk) begin
        if (sclr) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = DRAIN;
            DRAIN:   if (hs && out_last) state_nx = load ? DRAIN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            word_q   <= '0;
            pend_q   <= '0;
            out_data <= '0;
            out_lane <= '0;
            out_last <= 1'b0;
        end else if (load && in_chain) begin
            word_q   <= in_data;
            pend_q   <= '0;
            out_data <= in_data & lane_bits(in_mask);
            out_lane <= 2'd3;
            out_last <= 1'b1;
        end else if (load || adv) begin
            if (load) word_q <= in_data;
            pend_q   <= nx_rest;
            out_data <= ext_lane(src_data, nx_lane);
            out_lane <= nx_lane;
            out_last <= (nx_rest == 4'd0);
        end
    end

`ifdef SMUL_UNPACK_PERF_EN
    always_ff @(posedge clk) begin
        if (sclr)                     perf_lanes <= '0;
        else if (hs && perf_lanes != '1) perf_lanes <= perf_lanes + 1'b1;
    end
`endif

endmodule

// File: tb/tb_smul_result_unpacker.sv
// Directed self-checking bench for smul_result_unpacker (SIGNED_EXT=1).
module tb_smul_result_unpacker;

    logic        clk = 1'b0;
    logic        sclr;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [3:0]  in_mask;
    logic        in_chain;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [1:0]  out_lane;
    logic        out_last;
`ifdef SMUL_UNPACK_PERF_EN
    logic [15:0] perf_lanes;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    smul_result_unpacker #(.SIGNED_EXT(1), .CNT_W(16)) dut (
        .clk(clk), .sclr(sclr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mask(in_mask), .in_chain(in_chain),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_lane(out_lane), .out_last(out_last)
`ifdef SMUL_UNPACK_PERF_EN
        , .perf_lanes(perf_lanes)
`endif
    );

    task automatic send(input logic [63:0] d, input logic [3:0] m, input logic c);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_mask = m; in_chain = c;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic chk_beat(input string nm, input logic [63:0] d, input logic [1:0] l, input logic last);
        nvec++;
        if (out_valid !== 1'b1 || out_data !== d || out_lane !== l || out_last !== last) begin
            nerr++;
            $display("FAIL %s: got v=%b d=%h l=%0d last=%b, want v=1 d=%h l=%0d last=%b",
                     nm, out_valid, out_data, out_lane, out_last, d, l, last);
        end
    endtask

    task automatic chk_idle(input string nm);
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL %s: out_valid=%b want 0", nm, out_valid);
        end
    endtask

    task automatic test_reset();
        sclr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_mask = '0; in_chain = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            nvec++;
            if (in_ready !== 1'b0) begin
                nerr++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
            end
        end
        nvec++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || out_lane !== 2'd0 || out_last !== 1'b0) begin
            nerr++;
            $display("FAIL reset_outs: v=%b d=%h l=%0d last=%b want all 0", out_valid, out_data, out_lane, out_last);
        end
        sclr = 1'b0;
        @(negedge clk); #1;
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_full_mask();
        logic [63:0] exp_d [4];
        exp_d[0] = 64'h5; exp_d[1] = 64'hFFFFFFFFFFFFFF80;
        exp_d[2] = 64'h7FFF; exp_d[3] = 64'hFFFFFFFF80000001;
        out_ready = 1'b1;
        send(64'h80000001_7FFF_80_05, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_beat($sformatf("full_L%0d", i), exp_d[i], 2'(i), i == 3);
        end
        @(negedge clk);
        chk_idle("full_end");
`ifdef SMUL_UNPACK_PERF_EN
        nvec++;
        if (perf_lanes !== 16'd4) begin
            nerr++; $display("FAIL perf_full: got %0d want 4", perf_lanes);
        end
`endif
    endtask

    task automatic test_sparse_stall();
        out_ready = 1'b0;
        send(64'h11223344_5566_A5_88, 4'b1010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk_beat($sformatf("stall_L1_c%0d", i), 64'hFFFFFFFFFFFFFFA5, 2'd1, 1'b0);
            nvec++;
            if (in_ready !== 1'b0) begin
                nerr++; $display("FAIL stall_in_ready: got %b want 0", in_ready);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk_beat("sparse_L3", 64'h11223344, 2'd3, 1'b1);
        @(negedge clk);
        chk_idle("sparse_end");
    endtask

    task automatic test_chain();
        out_ready = 1'b1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 4'b0111, 1'b1);
        @(negedge clk);
        chk_beat("chain", 64'h0000_0000_FFFF_FFFF, 2'd3, 1'b1);
        @(negedge clk);
        chk_idle("chain_end");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0000_0077; in_mask = 4'h0; in_chain = 1'b0;
        @(posedge clk);
        #1 in_data = 64'h12; in_mask = 4'h1;
        @(negedge clk); #1;
        chk_idle("empty_no_beat");
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++; $display("FAIL empty_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1 in_data = 64'hF0;
        @(negedge clk);
        chk_beat("b2b_B", 64'h12, 2'd0, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk_beat("b2b_C", 64'hFFFFFFFFFFFFFFF0, 2'd0, 1'b1);
        @(negedge clk);
        chk_idle("b2b_end");
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        send(64'h80000001_7FFF_80_05, 4'hF, 1'b0);
        @(negedge clk);
        chk_beat("mr_L0", 64'h5, 2'd0, 1'b0);
        @(negedge clk);
        chk_beat("mr_L1", 64'hFFFFFFFFFFFFFF80, 2'd1, 1'b0);
        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        chk_idle("mr_after_sclr");
`ifdef SMUL_UNPACK_PERF_EN
        nvec++;
        if (perf_lanes !== 16'd0) begin
            nerr++; $display("FAIL perf_mid_reset: got %0d want 0", perf_lanes);
        end
`endif
        repeat (3) begin
            @(negedge clk);
            chk_idle("mr_no_more_beats");
        end
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_sparse_stall();
        test_chain();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
